// File: rtl/game_pkg.sv
// Shared definitions for the Segment Runner game core: state encoding, field/score
// widths and the obstacle LFSR seed, taps and step helpers.
package game_pkg;

  localparam int FIELD_W = 6;
  localparam int SCORE_W = 14;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READY = 4'b0010,
    ST_RUN   = 4'b0100,
    ST_OVER  = 4'b1000
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 for a left-shifting Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Low two bits the register will hold after one advance; selects the new column.
  function automatic logic [1:0] lfsr_low2_next(input logic [7:0] cur);
    return {cur[0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_if.sv
// Front-end/display side of the game core: login and button in, field maps,
// player position, tick, one-hot state and score out.
interface game_if;
  import game_pkg::*;

  logic               LoggedIn;
  logic               GameButton;
  logic [FIELD_W-1:0] FloorBits;
  logic [FIELD_W-1:0] CeilingBits;
  logic               PlayerPos;
  logic               GameTick;
  logic [3:0]         GameState;
  logic [SCORE_W-1:0] GameScore;

  modport master (
    output LoggedIn, GameButton,
    input  FloorBits, CeilingBits, PlayerPos, GameTick, GameState, GameScore
  );

  modport slave (
    input  LoggedIn, GameButton,
    output FloorBits, CeilingBits, PlayerPos, GameTick, GameState, GameScore
  );

endinterface

// File: rtl/game_lfsr.sv
// 8-bit Fibonacci LFSR for obstacle generation; synchronous reset to the seed and
// advances only when adv_i is high.
module game_lfsr
  import game_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/game_controller.sv
// Segment Runner core: login gating, obstacle scrolling, player swap, collision and
// saturating score. Optional macro SPEEDUP_EN halves the tick period once score >= 32.
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int SCORE_MAX = 9999
) (
  input logic   Clk,
  input logic   Rst,
  game_if.slave gif
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]   TC_NORM   = DIV_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);
`ifdef SPEEDUP_EN
  localparam int HALF_TC = ((TICK_DIV / 2 - 1) < 1) ? 1 : (TICK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]   TC_FAST   = DIV_W'(HALF_TC);
`endif

  state_e             state_q;
  logic [FIELD_W-1:0] floor_q;
  logic [FIELD_W-1:0] ceil_q;
  logic               pos_q;
  logic               tick_q;
  logic               btn_q;
  logic [DIV_W-1:0]   div_q;
  logic [SCORE_W-1:0] score_q;

  logic [7:0]         lfsr_q;
  logic [DIV_W-1:0]   div_tc;
  logic [1:0]         col_sel;
  logic               press;
  logic               collision;
  logic               tick_due;
  logic               blocked;
  logic               new_f;
  logic               new_c;

  assign press     = gif.GameButton & ~btn_q;
  assign collision = pos_q ? ceil_q[0] : floor_q[0];
`ifdef SPEEDUP_EN
  assign div_tc    = (score_q >= SCORE_W'(32)) ? TC_FAST : TC_NORM;
`else
  assign div_tc    = TC_NORM;
`endif
  assign tick_due  = gif.LoggedIn && (state_q == ST_RUN) && !collision && (div_q == div_tc);

  // Entry column comes from the post-advance LFSR; an occupied entry column forces a gap.
  assign col_sel   = lfsr_low2_next(lfsr_q);
  assign blocked   = floor_q[FIELD_W-1] | ceil_q[FIELD_W-1];
  assign new_f     = !blocked && (col_sel == 2'b00);
  assign new_c     = !blocked && (col_sel == 2'b01);

  game_lfsr u_lfsr (
    .clk_i (Clk),
    .rst_i (Rst),
    .adv_i (tick_due),
    .q_o   (lfsr_q)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      ceil_q  <= '0;
      pos_q   <= 1'b0;
      tick_q  <= 1'b0;
      btn_q   <= 1'b0;
      div_q   <= '0;
      score_q <= '0;
    end else begin
      btn_q  <= gif.GameButton;
      tick_q <= 1'b0;
      if (!gif.LoggedIn) begin
        state_q <= ST_IDLE;
        floor_q <= '0;
        ceil_q  <= '0;
        pos_q   <= 1'b0;
        div_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_READY;
            score_q <= '0;
          end
          ST_READY: begin
            if (press) begin
              state_q <= ST_RUN;
              floor_q <= '0;
              ceil_q  <= '0;
              pos_q   <= 1'b0;
              div_q   <= '0;
            end
          end
          ST_RUN: begin
            if (collision) begin
              state_q <= ST_OVER;
              div_q   <= '0;
            end else begin
              if (press) begin
                pos_q <= ~pos_q;
              end
              if (tick_due) begin
                div_q   <= '0;
                tick_q  <= 1'b1;
                floor_q <= {new_f, floor_q[FIELD_W-1:1]};
                ceil_q  <= {new_c, ceil_q[FIELD_W-1:1]};
                score_q <= (score_q >= SCORE_SAT) ? SCORE_SAT : score_q + SCORE_W'(1);
              end else begin
                div_q <= div_q + DIV_W'(1);
              end
            end
          end
          ST_OVER: begin
            if (press) begin
              state_q <= ST_READY;
              score_q <= '0;
              floor_q <= '0;
              ceil_q  <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            floor_q <= '0;
            ceil_q  <= '0;
            pos_q   <= 1'b0;
            div_q   <= '0;
          end
        endcase
      end
    end
  end

  assign gif.FloorBits   = floor_q;
  assign gif.CeilingBits = ceil_q;
  assign gif.PlayerPos   = pos_q;
  assign gif.GameTick    = tick_q;
  assign gif.GameState   = state_q;
  assign gif.GameScore   = score_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: a rule-level game model tracks the main
// instance; a second instance with a fast tick is steered clear of obstacles up to score saturation.
module tb_game_controller;
  import game_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  game_if gif1 ();
  game_if gif2 ();

  game_controller #(.TICK_DIV(4), .SCORE_MAX(9999)) dut (
    .Clk (Clk), .Rst (Rst), .gif (gif1)
  );
  game_controller #(.TICK_DIV(2), .SCORE_MAX(9999)) dut_sat (
    .Clk (Clk), .Rst (Rst), .gif (gif2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: state 0 idle, 1 ready, 2 run, 3 over
  int         m_state;
  logic [5:0] m_floor, m_ceil;
  logic       m_pos, m_tick, m_btn;
  int         m_score, m_cnt;
  logic [7:0] m_lfsr;

  function automatic logic [3:0] onehot(input int s);
    logic [3:0] r;
    r = 4'b0001 << s;
    return r;
  endfunction

  function automatic logic [31:0] exp_vec();
    return {onehot(m_state), m_floor, m_ceil, m_pos, m_tick, 14'(m_score)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {gif1.GameState, gif1.FloorBits, gif1.CeilingBits, gif1.PlayerPos,
            gif1.GameTick, gif1.GameScore};
  endfunction

  task automatic model_step(input logic li, input logic btn, input logic rst);
    logic press, hit, gap, nf, nc;
    int   period;
    if (rst) begin
      m_state = 0; m_floor = 6'd0; m_ceil = 6'd0; m_pos = 1'b0; m_tick = 1'b0;
      m_btn = 1'b0; m_score = 0; m_cnt = 0; m_lfsr = 8'hA5;
      return;
    end
    press  = btn && !m_btn;
    m_btn  = btn;
    m_tick = 1'b0;
    period = 4;
`ifdef SPEEDUP_EN
    if (m_score >= 32) period = 2;
`endif
    if (!li) begin
      m_state = 0; m_floor = 6'd0; m_ceil = 6'd0; m_pos = 1'b0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_score = 0;
    end else if (m_state == 1) begin
      if (press) begin
        m_state = 2; m_floor = 6'd0; m_ceil = 6'd0; m_pos = 1'b0; m_cnt = 0;
      end
    end else if (m_state == 2) begin
      hit = m_pos ? m_ceil[0] : m_floor[0];
      if (hit) begin
        m_state = 3; m_cnt = 0;
      end else begin
        if (press) m_pos = !m_pos;
        m_cnt = m_cnt + 1;
        if (m_cnt == period) begin
          m_cnt   = 0;
          m_tick  = 1'b1;
          m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
          gap     = m_floor[5] | m_ceil[5];
          nf      = !gap && (m_lfsr[1:0] == 2'b00);
          nc      = !gap && (m_lfsr[1:0] == 2'b01);
          m_floor = {nf, m_floor[5:1]};
          m_ceil  = {nc, m_ceil[5:1]};
          m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
        end
      end
    end else begin
      if (press) begin
        m_state = 1; m_score = 0; m_floor = 6'd0; m_ceil = 6'd0;
      end
    end
  endtask

  task automatic cycle(input logic li, input logic btn, input logic rst);
    gif1.LoggedIn   = li;
    gif1.GameButton = btn;
    Rst             = rst;
    model_step(li, btn, rst);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 32'h1000_0000) begin
      n_fail++; $display("FAIL reset got %h want %h", dut_vec(), 32'h1000_0000);
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL idle_hold got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start;
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (gif1.GameState !== 4'b0010) begin
      n_fail++; $display("FAIL login got %b want 0010", gif1.GameState);
    end
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (gif1.GameState !== 4'b0100) begin
      n_fail++; $display("FAIL start got %b want 0100", gif1.GameState);
    end
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL run_cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 3) begin
        n_cmp++;
        if (gif1.GameTick !== 1'b0) begin
          n_fail++; $display("FAIL early_tick got %b want 0", gif1.GameTick);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (gif1.GameTick !== 1'b1 || gif1.GameScore !== 14'd1) begin
          n_fail++; $display("FAIL first_tick got tick=%b score=%0d want 1/1", gif1.GameTick, gif1.GameScore);
        end
      end
      if (i == 12) begin
        n_cmp++;
        if (gif1.GameScore !== 14'd3) begin
          n_fail++; $display("FAIL score3 got %0d want 3", gif1.GameScore);
        end
      end
    end
  endtask

  task automatic test_toggle;
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (gif1.PlayerPos !== 1'b1) begin
      n_fail++; $display("FAIL toggle_pulse got %b want 1", gif1.PlayerPos);
    end
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL toggle_hold%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (gif1.PlayerPos !== 1'b0) begin
      n_fail++; $display("FAIL toggle_once got %b want 0", gif1.PlayerPos);
    end
  endtask

  task automatic test_collision;
    int         budget;
    int         frozen_score;
    logic [5:0] frozen_floor;
    budget = 0;
    while (m_state != 3 && budget < 600) begin
      cycle(1'b1, 1'b0, 1'b0);
      budget++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pre_hit%0d got %h want %h", budget, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (gif1.GameState !== 4'b1000) begin
      n_fail++; $display("FAIL collision got %b want 1000 after %0d cycles", gif1.GameState, budget);
    end
    frozen_score = m_score;
    frozen_floor = m_floor;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (gif1.GameTick !== 1'b0 || gif1.GameScore !== 14'(frozen_score) ||
          gif1.FloorBits !== frozen_floor) begin
        n_fail++; $display("FAIL freeze%0d got tick=%b score=%0d floor=%b want 0/%0d/%b",
                           i, gif1.GameTick, gif1.GameScore, gif1.FloorBits, frozen_score, frozen_floor);
      end
    end
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (gif1.GameState !== 4'b0010 || gif1.GameScore !== 14'd0) begin
      n_fail++; $display("FAIL restart got %b/%0d want 0010/0", gif1.GameState, gif1.GameScore);
    end
  endtask

  task automatic test_logout_and_midreset;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (gif1.GameState !== 4'b0001 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL logout got %h want %h", dut_vec(), exp_vec());
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 32'h1000_0000) begin
      n_fail++; $display("FAIL mid_reset got %h want %h", dut_vec(), 32'h1000_0000);
    end
  endtask

  task automatic test_random;
    logic li, btn;
    for (int i = 0; i < 3000; i++) begin
      li  = ($urandom_range(0, 199) != 0);
      btn = ($urandom_range(0, 3) == 0);
      cycle(li, btn, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation;
    logic need;
    int   ticks, want;
    bit   alive;
    gif2.GameButton = 1'b0;
    gif2.LoggedIn   = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    gif2.GameButton = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    gif2.GameButton = 1'b0;
    n_cmp++;
    if (gif2.GameState !== 4'b0100) begin
      n_fail++; $display("FAIL sat_start got %b want 0100", gif2.GameState);
    end
    alive = 1'b1;
    // Ticks land on even cycles; on odd cycles swap sides if the next arriving column is ours.
    for (int k = 1; k <= 20002 && alive; k++) begin
      need = 1'b0;
      if (k % 2 == 1) need = gif2.PlayerPos ? gif2.CeilingBits[1] : gif2.FloorBits[1];
      gif2.GameButton = need;
      cycle(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (gif2.GameState !== 4'b0100) begin
        n_fail++; alive = 1'b0;
        $display("FAIL sat_alive cyc%0d got %b want 0100", k, gif2.GameState);
      end else if (k % 2 == 0) begin
        ticks = k / 2;
        if (ticks == 1 || ticks == 2 || ticks == 5000 || ticks >= 9998) begin
          want = (ticks > 9999) ? 9999 : ticks;
          n_cmp++;
          if (gif2.GameScore !== 14'(want)) begin
            n_fail++; $display("FAIL sat_tick%0d got %0d want %0d", ticks, gif2.GameScore, want);
          end
        end
      end
    end
    gif2.GameButton = 1'b0;
  endtask

  initial begin
    gif1.LoggedIn = 1'b0; gif1.GameButton = 1'b0;
    gif2.LoggedIn = 1'b0; gif2.GameButton = 1'b0;
    Rst = 1'b1;
    test_reset();
    test_start();
    test_toggle();
    test_collision();
    test_logout_and_midreset();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
